// File: rtl/fcc_if.sv
// Memory bundles of the fully-connected core: one read bundle per operand
// stream (data, weights, bias) and one write bundle for results.
interface fcc_rd_if #(
  parameter int ADDR_WIDTH = 19,
  parameter int DP_DEPTH   = 32
);
  localparam int SIZE_W = $clog2(DP_DEPTH) + 1;

  logic                     mem_req;
  logic [ADDR_WIDTH-1:0]    mem_start_addr;
  logic [SIZE_W-1:0]        mem_size_bytes;
  logic                     mem_valid;
  logic                     last;
  logic [DP_DEPTH-1:0][7:0] mem_data;
  logic [4:0]               mem_last_valid;

  modport master (
    output mem_req, mem_start_addr, mem_size_bytes,
    input  mem_valid, last, mem_data, mem_last_valid
  );

  modport slave (
    input  mem_req, mem_start_addr, mem_size_bytes,
    output mem_valid, last, mem_data, mem_last_valid
  );
endinterface

interface fcc_wr_if #(
  parameter int ADDR_WIDTH = 19,
  parameter int DP_DEPTH   = 32
);
  localparam int SIZE_W = $clog2(DP_DEPTH) + 1;

  logic                     mem_req;
  logic [ADDR_WIDTH-1:0]    mem_start_addr;
  logic [SIZE_W-1:0]        mem_size_bytes;
  logic                     last;
  logic [DP_DEPTH-1:0][7:0] mem_data;
  logic [4:0]               mem_last_valid;
  logic                     mem_ack;

  modport master (
    output mem_req, mem_start_addr, mem_size_bytes, last, mem_data, mem_last_valid,
    input  mem_ack
  );

  modport slave (
    input  mem_req, mem_start_addr, mem_size_bytes, last, mem_data, mem_last_valid,
    output mem_ack
  );
endinterface

// File: rtl/fcc.sv
// Fully-connected layer engine: per neuron, bias + sum of uint8 data x int8
// weights over the input vector, one 32-byte chunk per MAC step, result written back.
module fcc #(
  parameter int DP_DEPTH             = 32,
  parameter int ADDR_WIDTH           = 19,
  parameter int MAX_BYTES_TO_RD      = 32,
  parameter int LOG2_MAX_BYTES_TO_RD = 5,
  parameter int MAX_BYTES_TO_WR      = 32,
  parameter int LOG2_MAX_BYTES_TO_WR = 5,
  parameter int MEM_DATA_BUS         = 256,
  parameter int X_ROWS_NUM           = 128,
  parameter int X_COLS_NUM           = 1,
  parameter int Y_ROWS_NUM           = 128,
  parameter int Y_COLS_NUM           = 128,
  parameter int CNT_32_MAX           = X_ROWS_NUM / 32,
  parameter int X_LOG2_ROWS_NUM      = $clog2(X_ROWS_NUM),
  parameter int Y_LOG2_ROWS_NUM      = $clog2(Y_ROWS_NUM),
  parameter int Y_LOG2_COLS_NUM      = $clog2(Y_COLS_NUM)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fc_go,
  output logic                       fc_done,
  output logic                       fc_sw_busy_ind,
  input  logic [ADDR_WIDTH-1:0]      fc_addrx,
  input  logic [ADDR_WIDTH-1:0]      fc_addry,
  input  logic [ADDR_WIDTH-1:0]      fc_addrb,
  input  logic [ADDR_WIDTH-1:0]      fc_addrz,
  input  logic [X_LOG2_ROWS_NUM-1:0] fc_xm,
  input  logic [Y_LOG2_ROWS_NUM-1:0] fc_ym,
  input  logic [Y_LOG2_COLS_NUM-1:0] fc_yn,
  input  logic [X_LOG2_ROWS_NUM-1:0] cnn_bn,
  fcc_rd_if.master                   mem_intf_read_pic,
  fcc_rd_if.master                   mem_intf_read_wgt,
  fcc_rd_if.master                   mem_intf_read_bias,
  fcc_wr_if.master                   mem_intf_write
);

  localparam int SIZE_W  = $clog2(DP_DEPTH) + 1;
  localparam int LOG2_DP = $clog2(DP_DEPTH);
  localparam int NW      = Y_LOG2_ROWS_NUM + 1;
  localparam int KW      = $clog2(CNT_32_MAX) + 1;
  localparam int PROD_W  = 17;
  localparam int SUM_W   = PROD_W + LOG2_DP;

  typedef enum logic [2:0] {
    IDLE,
    RD_BIAS,
    RD_PIC,
    RD_WGT,
    MAC,
    WR,
    DONE
  } state_t;

  state_t                   state_reg, state_next;
  logic [NW-1:0]            n_reg, n_next;
  logic [KW-1:0]            k_reg, k_next;
  logic signed [31:0]       acc_reg, acc_next;
  logic                     load_pic, load_wgt;
  logic [DP_DEPTH-1:0][7:0] pic_reg, wgt_reg;
  logic signed [PROD_W-1:0] prod [DP_DEPTH];
  logic signed [SUM_W-1:0]  dot_sum;
  logic [NW-1:0]            n_total;
  logic [NW-1:0]            n_inc;
  logic                     k_last;
  logic [ADDR_WIDTH-1:0]    bias_addr, pic_addr, wgt_addr, res_addr;

  // A zero neuron count selects the full layer size.
  assign n_total = (fc_ym == '0) ? NW'(Y_ROWS_NUM) : NW'(fc_ym);
  assign n_inc   = n_reg + 1'b1;
  assign k_last  = (k_reg == KW'(CNT_32_MAX - 1));

  assign bias_addr = fc_addrb + (ADDR_WIDTH'(n_reg) << 2);
  assign pic_addr  = fc_addrx + (ADDR_WIDTH'(k_reg) << LOG2_DP);
  assign wgt_addr  = fc_addry + ADDR_WIDTH'(n_reg) * ADDR_WIDTH'(X_ROWS_NUM)
                   + (ADDR_WIDTH'(k_reg) << LOG2_DP);
  assign res_addr  = fc_addrz + (ADDR_WIDTH'(n_reg) << 2);

  // Data bytes are unsigned, weights signed: widen both to the product width.
  genvar gi;
  generate
    for (gi = 0; gi < DP_DEPTH; gi++) begin : g_prod
      assign prod[gi] = $signed({{(PROD_W-8){1'b0}}, pic_reg[gi]})
                      * $signed({{(PROD_W-8){wgt_reg[gi][7]}}, wgt_reg[gi]});
    end
  endgenerate

  always_comb begin
    dot_sum = '0;
    for (int i = 0; i < DP_DEPTH; i++) begin
      dot_sum = dot_sum + SUM_W'(prod[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      n_reg     <= '0;
      k_reg     <= '0;
      acc_reg   <= '0;
    end else begin
      state_reg <= state_next;
      n_reg     <= n_next;
      k_reg     <= k_next;
      acc_reg   <= acc_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pic_reg <= '0;
      wgt_reg <= '0;
    end else begin
      if (load_pic) pic_reg <= mem_intf_read_pic.mem_data;
      if (load_wgt) wgt_reg <= mem_intf_read_wgt.mem_data;
    end
  end

  always_comb begin
    state_next = state_reg;
    n_next     = n_reg;
    k_next     = k_reg;
    acc_next   = acc_reg;
    load_pic   = 1'b0;
    load_wgt   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (fc_go) begin
          state_next = RD_BIAS;
          n_next     = '0;
          k_next     = '0;
        end
      end
      RD_BIAS: begin
        if (mem_intf_read_bias.mem_valid) begin
          acc_next   = $signed(mem_intf_read_bias.mem_data[3:0]);
          state_next = RD_PIC;
        end
      end
      RD_PIC: begin
        if (mem_intf_read_pic.mem_valid) begin
          load_pic   = 1'b1;
          state_next = RD_WGT;
        end
      end
      RD_WGT: begin
        if (mem_intf_read_wgt.mem_valid) begin
          load_wgt   = 1'b1;
          state_next = MAC;
        end
      end
      MAC: begin
        acc_next   = acc_reg + 32'(dot_sum);
        k_next     = k_reg + 1'b1;
        state_next = k_last ? WR : RD_PIC;
      end
      WR: begin
        if (mem_intf_write.mem_ack) begin
          n_next     = n_inc;
          k_next     = '0;
          state_next = (n_inc < n_total) ? RD_BIAS : DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Bus outputs decode straight from the state, so reset clears them at once.
  always_comb begin
    fc_done        = (state_reg == DONE);
    fc_sw_busy_ind = (state_reg != IDLE) && (state_reg != DONE);

    mem_intf_read_bias.mem_req        = 1'b0;
    mem_intf_read_bias.mem_start_addr = '0;
    mem_intf_read_bias.mem_size_bytes = '0;
    mem_intf_read_pic.mem_req         = 1'b0;
    mem_intf_read_pic.mem_start_addr  = '0;
    mem_intf_read_pic.mem_size_bytes  = '0;
    mem_intf_read_wgt.mem_req         = 1'b0;
    mem_intf_read_wgt.mem_start_addr  = '0;
    mem_intf_read_wgt.mem_size_bytes  = '0;
    mem_intf_write.mem_req            = 1'b0;
    mem_intf_write.mem_start_addr     = '0;
    mem_intf_write.mem_size_bytes     = '0;
    mem_intf_write.last               = 1'b0;
    mem_intf_write.mem_data           = '0;
    mem_intf_write.mem_last_valid     = '0;

    case (state_reg)
      RD_BIAS: begin
        mem_intf_read_bias.mem_req        = 1'b1;
        mem_intf_read_bias.mem_start_addr = bias_addr;
        mem_intf_read_bias.mem_size_bytes = SIZE_W'(4);
      end
      RD_PIC: begin
        mem_intf_read_pic.mem_req         = 1'b1;
        mem_intf_read_pic.mem_start_addr  = pic_addr;
        mem_intf_read_pic.mem_size_bytes  = SIZE_W'(DP_DEPTH);
      end
      RD_WGT: begin
        mem_intf_read_wgt.mem_req         = 1'b1;
        mem_intf_read_wgt.mem_start_addr  = wgt_addr;
        mem_intf_read_wgt.mem_size_bytes  = SIZE_W'(DP_DEPTH);
      end
      WR: begin
        mem_intf_write.mem_req            = 1'b1;
        mem_intf_write.mem_start_addr     = res_addr;
        mem_intf_write.mem_size_bytes     = SIZE_W'(4);
        mem_intf_write.last               = 1'b1;
        mem_intf_write.mem_data[3:0]      = acc_reg;
        mem_intf_write.mem_last_valid     = 5'd3;
      end
      default: begin
      end
    endcase
  end

  // Inputs and parameters kept for interface compatibility but not used.
  logic unused_ok;
  assign unused_ok = &{1'b0, fc_xm, fc_yn, cnn_bn,
                       mem_intf_read_pic.last,  mem_intf_read_pic.mem_last_valid,
                       mem_intf_read_wgt.last,  mem_intf_read_wgt.mem_last_valid,
                       mem_intf_read_bias.last, mem_intf_read_bias.mem_last_valid,
                       mem_intf_read_bias.mem_data[DP_DEPTH-1:4],
                       MAX_BYTES_TO_RD[0], LOG2_MAX_BYTES_TO_RD[0],
                       MAX_BYTES_TO_WR[0], LOG2_MAX_BYTES_TO_WR[0],
                       MEM_DATA_BUS[0], X_COLS_NUM[0], Y_COLS_NUM[0]};

endmodule

// File: tb/tb_fcc.sv
// Directed bench for fcc: memory models answer the three read bundles and the
// write bundle; each task checks one scenario against hand-computed values.
`timescale 1ns/1ps
module tb_fcc;
  localparam int AW = 19;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fc_go = 1'b0;
  logic          fc_done, fc_sw_busy_ind;
  logic [AW-1:0] fc_addrx, fc_addry, fc_addrb, fc_addrz;
  logic [6:0]    fc_xm, fc_ym, fc_yn, cnn_bn;

  always #5 clk = ~clk;

  fcc_rd_if #(.ADDR_WIDTH(AW), .DP_DEPTH(32)) rd_pic ();
  fcc_rd_if #(.ADDR_WIDTH(AW), .DP_DEPTH(32)) rd_wgt ();
  fcc_rd_if #(.ADDR_WIDTH(AW), .DP_DEPTH(32)) rd_bias ();
  fcc_wr_if #(.ADDR_WIDTH(AW), .DP_DEPTH(32)) wr ();

  fcc dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .fc_go              (fc_go),
    .fc_done            (fc_done),
    .fc_sw_busy_ind     (fc_sw_busy_ind),
    .fc_addrx           (fc_addrx),
    .fc_addry           (fc_addry),
    .fc_addrb           (fc_addrb),
    .fc_addrz           (fc_addrz),
    .fc_xm              (fc_xm),
    .fc_ym              (fc_ym),
    .fc_yn              (fc_yn),
    .cnn_bn             (cnn_bn),
    .mem_intf_read_pic  (rd_pic.master),
    .mem_intf_read_wgt  (rd_wgt.master),
    .mem_intf_read_bias (rd_bias.master),
    .mem_intf_write     (wr.master)
  );

  logic [31:0] bias_mem [128];
  logic [7:0]  pic_mem  [128];
  logic [7:0]  wgt_mem  [16384];

  int checks = 0;
  int failures = 0;

  // Read responders: answer one cycle after the request is seen.
  always @(negedge clk) begin
    if (rd_bias.mem_req && !rd_bias.mem_valid) begin
      logic [AW-1:0] off;
      off = rd_bias.mem_start_addr - fc_addrb;
      rd_bias.mem_data = '0;
      rd_bias.mem_data[3:0] = bias_mem[off[8:2]];
      rd_bias.mem_valid = 1'b1;
    end else begin
      rd_bias.mem_valid = 1'b0;
    end
    rd_bias.last = 1'b0;
    rd_bias.mem_last_valid = '0;
  end

  always @(negedge clk) begin
    if (rd_pic.mem_req && !rd_pic.mem_valid) begin
      logic [AW-1:0] off;
      off = rd_pic.mem_start_addr - fc_addrx;
      for (int i = 0; i < 32; i++) rd_pic.mem_data[i] = pic_mem[(int'(off) + i) % 128];
      rd_pic.mem_valid = 1'b1;
    end else begin
      rd_pic.mem_valid = 1'b0;
    end
    rd_pic.last = 1'b0;
    rd_pic.mem_last_valid = '0;
  end

  always @(negedge clk) begin
    if (rd_wgt.mem_req && !rd_wgt.mem_valid) begin
      logic [AW-1:0] off;
      off = rd_wgt.mem_start_addr - fc_addry;
      for (int i = 0; i < 32; i++) rd_wgt.mem_data[i] = wgt_mem[(int'(off) + i) % 16384];
      rd_wgt.mem_valid = 1'b1;
    end else begin
      rd_wgt.mem_valid = 1'b0;
    end
    rd_wgt.last = 1'b0;
    rd_wgt.mem_last_valid = '0;
  end

  // Monitor plus write responder: logs request rising edges and completed writes.
  int              ev_n = 0;
  int              ev_type [8192];
  logic [AW-1:0]   ev_addr [8192];
  int              wr_n = 0;
  logic [AW-1:0]   wr_addr [2048];
  logic [31:0]     wr_val  [2048];
  logic            wr_meta [2048];
  int              wr_cyc  [2048];
  int              done_n = 0;
  int              excl_err = 0;
  int              unstable = 0;
  int              ack_delay = 0;
  int              wait_cnt = 0;
  logic [3:0]      reqs, prev_reqs = 4'b0;
  logic [AW-1:0]   hold_addr;
  logic [31:0][7:0] hold_data;

  always @(negedge clk) begin
    reqs = {wr.mem_req, rd_wgt.mem_req, rd_pic.mem_req, rd_bias.mem_req};
    if ($countones(reqs) > 1) excl_err++;
    for (int i = 0; i < 4; i++) begin
      if (reqs[i] && !prev_reqs[i] && ev_n < 8192) begin
        ev_type[ev_n] = i;
        case (i)
          0:       ev_addr[ev_n] = rd_bias.mem_start_addr;
          1:       ev_addr[ev_n] = rd_pic.mem_start_addr;
          2:       ev_addr[ev_n] = rd_wgt.mem_start_addr;
          default: ev_addr[ev_n] = wr.mem_start_addr;
        endcase
        ev_n++;
      end
    end
    prev_reqs = reqs;
    if (fc_done) done_n++;
    if (wr.mem_req && !wr.mem_ack) begin
      if (wait_cnt > 0 && (wr.mem_start_addr != hold_addr || wr.mem_data != hold_data))
        unstable++;
      hold_addr = wr.mem_start_addr;
      hold_data = wr.mem_data;
      if (wait_cnt >= ack_delay) begin
        wr.mem_ack = 1'b1;
        wr_addr[wr_n % 2048] = wr.mem_start_addr;
        wr_val[wr_n % 2048]  = wr.mem_data[3:0];
        wr_meta[wr_n % 2048] = (wr.mem_size_bytes == 6'd4) && wr.last &&
                               (wr.mem_last_valid == 5'd3) && (wr.mem_data[31:4] == '0);
        wr_cyc[wr_n % 2048]  = wait_cnt + 1;
        wr_n++;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wr.mem_ack = 1'b0;
    end
    if (!rst_n) begin
      wait_cnt = 0;
      wr.mem_ack = 1'b0;
    end
  end

  // Pulses go for one edge and waits (bounded) for the next done pulse.
  task automatic run_job(input logic [6:0] ym, input int delay, output bit ok);
    int d0;
    fc_ym = ym;
    ack_delay = delay;
    d0 = done_n;
    @(negedge clk);
    fc_go = 1'b1;
    @(posedge clk);
    #1 fc_go = 1'b0;
    for (int c = 0; c < 20000 && done_n == d0; c++) @(negedge clk);
    ok = (done_n != d0);
    repeat (3) @(negedge clk);
  endtask

  task automatic fill(input logic [31:0] b, input logic [7:0] p, input logic [7:0] w);
    for (int i = 0; i < 128; i++) begin
      bias_mem[i] = b;
      pic_mem[i]  = p;
    end
    for (int i = 0; i < 16384; i++) wgt_mem[i] = w;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (reqs !== 4'b0) begin
      failures++; $display("FAIL reset_reqs: got %b expected 0000", reqs);
    end
    checks++;
    if ({fc_done, fc_sw_busy_ind} !== 2'b00) begin
      failures++; $display("FAIL reset_status: got %b expected 00", {fc_done, fc_sw_busy_ind});
    end
    checks++;
    if (|{rd_bias.mem_start_addr, rd_bias.mem_size_bytes, rd_pic.mem_start_addr,
          rd_pic.mem_size_bytes, rd_wgt.mem_start_addr, rd_wgt.mem_size_bytes,
          wr.mem_start_addr, wr.mem_size_bytes, wr.mem_data, wr.last, wr.mem_last_valid} !== 1'b0) begin
      failures++; $display("FAIL reset_buses: got nonzero expected all zero");
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (fc_sw_busy_ind !== 1'b0 || ev_n !== 0) begin
      failures++; $display("FAIL idle_after_reset: busy=%b events=%0d expected 0 0", fc_sw_busy_ind, ev_n);
    end
  endtask

  task automatic test_bias_only();
    bit ok; int w0, d0, bad_addr, bad_val, bad_meta;
    fill(32'd5, 8'd0, 8'd0);
    for (int i = 0; i < 16384; i++) wgt_mem[i] = 8'($urandom);
    w0 = wr_n; d0 = done_n;
    run_job(7'd0, 0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL bias_done_timeout: no done pulse"); end
    checks++;
    if (done_n - d0 !== 1) begin
      failures++; $display("FAIL bias_done_count: got %0d expected 1", done_n - d0);
    end
    checks++;
    if (wr_n - w0 !== 128) begin
      failures++; $display("FAIL bias_write_count: got %0d expected 128", wr_n - w0);
    end
    bad_addr = 0; bad_val = 0; bad_meta = 0;
    for (int i = 0; i < 128; i++) begin
      if (wr_addr[(w0 + i) % 2048] !== fc_addrz + 19'(4 * i)) bad_addr++;
      if (wr_val[(w0 + i) % 2048] !== 32'd5) bad_val++;
      if (wr_meta[(w0 + i) % 2048] !== 1'b1) bad_meta++;
    end
    checks++;
    if (bad_addr != 0) begin failures++; $display("FAIL bias_addr: %0d wrong, expected 0 wrong", bad_addr); end
    checks++;
    if (bad_val != 0) begin
      failures++; $display("FAIL bias_value: %0d wrong (first %0h) expected 5", bad_val, wr_val[w0 % 2048]);
    end
    checks++;
    if (bad_meta != 0) begin failures++; $display("FAIL bias_write_fields: %0d wrong expected 0", bad_meta); end
    checks++;
    if (fc_sw_busy_ind !== 1'b0) begin failures++; $display("FAIL bias_busy_end: got 1 expected 0"); end
  endtask

  task automatic test_full_layer(input logic [31:0] b, input logic [7:0] p, input logic [7:0] w,
                                 input logic [31:0] exp_val, input string name);
    bit ok; int w0, bad;
    fill(b, p, w);
    w0 = wr_n;
    run_job(7'd0, 0, ok);
    checks++;
    if (!ok || wr_n - w0 !== 128) begin
      failures++; $display("FAIL %s_count: got %0d writes expected 128", name, wr_n - w0);
    end
    bad = 0;
    for (int i = 0; i < 128; i++) if (wr_val[(w0 + i) % 2048] !== exp_val) bad++;
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL %s_value: first got %0h expected %0h (%0d wrong)", name, wr_val[w0 % 2048], exp_val, bad);
    end
  endtask

  task automatic load_mixed();
    fill(32'd0, 8'd2, 8'd1);
    bias_mem[1] = 32'hFFFF_FFF9;
    bias_mem[2] = 32'h7FFF_FFFF;
    for (int j = 0; j < 128; j++) begin
      wgt_mem[j]       = 8'd3;
      wgt_mem[128 + j] = (j < 64) ? 8'hFE : 8'h01;
    end
    fc_addrz = 19'h7FFFC;
  endtask

  task automatic test_mixed_order();
    bit ok; int w0, e0, idx;
    logic [AW-1:0] exp_a;
    logic [31:0] exp_v [3];
    logic [AW-1:0] exp_z [3];
    exp_v = '{32'h0000_0300, 32'hFFFF_FF79, 32'h8000_00FF};
    exp_z = '{19'h7FFFC, 19'h00000, 19'h00004};
    load_mixed();
    w0 = wr_n; e0 = ev_n;
    run_job(7'd3, 0, ok);
    checks++;
    if (!ok || wr_n - w0 !== 3) begin
      failures++; $display("FAIL mixed_count: got %0d writes expected 3", wr_n - w0);
    end
    for (int n = 0; n < 3; n++) begin
      checks++;
      if (wr_val[(w0 + n) % 2048] !== exp_v[n] || wr_addr[(w0 + n) % 2048] !== exp_z[n]) begin
        failures++; $display("FAIL mixed_neuron%0d: got %0h@%0h expected %0h@%0h", n,
          wr_val[(w0 + n) % 2048], wr_addr[(w0 + n) % 2048], exp_v[n], exp_z[n]);
      end
    end
    checks++;
    if (ev_n - e0 !== 30) begin
      failures++; $display("FAIL order_event_count: got %0d expected 30", ev_n - e0);
    end
    for (int n = 0; n < 2; n++) begin
      for (int s = 0; s < 10; s++) begin
        int t;
        idx = e0 + 10 * n + s;
        if (s == 0) begin t = 0; exp_a = fc_addrb + 19'(4 * n); end
        else if (s == 9) begin t = 3; exp_a = fc_addrz + 19'(4 * n); end
        else if (s % 2 == 1) begin t = 1; exp_a = fc_addrx + 19'(32 * ((s - 1) / 2)); end
        else begin t = 2; exp_a = fc_addry + 19'(128 * n + 32 * ((s - 2) / 2)); end
        checks++;
        if (ev_type[idx] !== t || ev_addr[idx] !== exp_a) begin
          failures++; $display("FAIL order_n%0d_s%0d: got type %0d addr %0h expected type %0d addr %0h",
            n, s, ev_type[idx], ev_addr[idx], t, exp_a);
        end
      end
    end
  endtask

  task automatic test_ack_delay();
    bit ok; int w0, e0, u0;
    load_mixed();
    w0 = wr_n; e0 = ev_n; u0 = unstable;
    run_job(7'd2, 5, ok);
    checks++;
    if (!ok || wr_n - w0 !== 2) begin
      failures++; $display("FAIL ack_count: got %0d writes expected 2", wr_n - w0);
    end
    checks++;
    if (wr_val[w0 % 2048] !== 32'h300 || wr_val[(w0 + 1) % 2048] !== 32'hFFFF_FF79) begin
      failures++; $display("FAIL ack_values: got %0h %0h expected 300 ffffff79", wr_val[w0 % 2048], wr_val[(w0 + 1) % 2048]);
    end
    checks++;
    if (wr_cyc[w0 % 2048] !== 6 || wr_cyc[(w0 + 1) % 2048] !== 6) begin
      failures++; $display("FAIL ack_hold_cycles: got %0d %0d expected 6 6", wr_cyc[w0 % 2048], wr_cyc[(w0 + 1) % 2048]);
    end
    checks++;
    if (unstable - u0 !== 0) begin
      failures++; $display("FAIL ack_stability: got %0d changes expected 0", unstable - u0);
    end
    checks++;
    if (ev_n - e0 !== 20) begin
      failures++; $display("FAIL ack_event_count: got %0d expected 20", ev_n - e0);
    end
    ack_delay = 0;
  endtask

  task automatic test_reset_mid();
    bit found, ok; int e_rst, e0, w0;
    fill(32'd0, 8'd1, 8'd1);
    fc_addrz = 19'h20000;
    fc_ym = 7'd0;
    found = 1'b0;
    @(negedge clk);
    fc_go = 1'b1;
    @(posedge clk);
    #1 fc_go = 1'b0;
    for (int c = 0; c < 3000 && !found; c++) begin
      @(negedge clk);
      if (rd_wgt.mem_req && rd_wgt.mem_start_addr == fc_addry + 19'd1280) found = 1'b1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL mid_reach_neuron10: not reached expected reached"); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({wr.mem_req, rd_wgt.mem_req, rd_pic.mem_req, rd_bias.mem_req, fc_done, fc_sw_busy_ind} !== 6'b0) begin
      failures++; $display("FAIL mid_reset_ctrl: got %b expected 000000",
        {wr.mem_req, rd_wgt.mem_req, rd_pic.mem_req, rd_bias.mem_req, fc_done, fc_sw_busy_ind});
    end
    checks++;
    if (|{rd_wgt.mem_start_addr, rd_wgt.mem_size_bytes, rd_pic.mem_start_addr,
          rd_bias.mem_start_addr, wr.mem_start_addr, wr.mem_data} !== 1'b0) begin
      failures++; $display("FAIL mid_reset_buses: got nonzero expected all zero");
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    e_rst = ev_n;
    repeat (5) @(negedge clk);
    checks++;
    if (ev_n !== e_rst || fc_sw_busy_ind !== 1'b0) begin
      failures++; $display("FAIL mid_idle: got %0d new events busy=%b expected 0 0", ev_n - e_rst, fc_sw_busy_ind);
    end
    e0 = ev_n; w0 = wr_n;
    run_job(7'd1, 0, ok);
    checks++;
    if (!ok || ev_type[e0] !== 0 || ev_addr[e0] !== fc_addrb) begin
      failures++; $display("FAIL mid_restart_first: got type %0d addr %0h expected type 0 addr %0h",
        ev_type[e0], ev_addr[e0], fc_addrb);
    end
    checks++;
    if (wr_n - w0 !== 1 || wr_val[w0 % 2048] !== 32'd128 || wr_addr[w0 % 2048] !== 19'h20000) begin
      failures++; $display("FAIL mid_restart_result: got %0d writes %0h@%0h expected 1 80@20000",
        wr_n - w0, wr_val[w0 % 2048], wr_addr[w0 % 2048]);
    end
  endtask

  task automatic test_exclusive();
    checks++;
    if (excl_err !== 0) begin
      failures++; $display("FAIL req_exclusive: got %0d overlapping cycles expected 0", excl_err);
    end
  endtask

  initial begin
    fc_addrx = 19'h01000;
    fc_addry = 19'h10000;
    fc_addrb = 19'h00200;
    fc_addrz = 19'h20000;
    fc_xm = 7'd0; fc_ym = 7'd0; fc_yn = 7'd0; cnn_bn = 7'd0;
    test_reset();
    test_bias_only();
    test_full_layer(32'd0, 8'd1, 8'd1, 32'd128, "ones");
    test_full_layer(32'd100, 8'd255, 8'hFF, 32'hFFFF_80E4, "neg");
    test_mixed_order();
    test_ack_delay();
    test_reset_mid();
    test_exclusive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
